// File: rtl/fp_add_round_pack.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fp_add_round_pack : FP32 adder stage 4 - RNE round, pack, 2-entry out queue
// Revision 1.0
// ----------------------------------------------------------------------------
module fp_add_round_pack #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  exp_large_out_s4,
  input  logic [7:0]  leading_zero_ctr,
  input  logic [23:0] left_shifted_mant,
  input  logic [2:0]  grs_s4,
  input  logic        sign_out_s4,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        flag_zero,
  output logic        flag_uf,
  output logic        flag_of
);

  logic              w_round_up;
  logic [24:0]       w_m25;
  logic              w_carry;
  logic [22:0]       w_frac;
  logic signed [9:0] w_exp;
  logic [31:0]       w_word;
  logic              w_zero;
  logic              w_uf;
  logic              w_of;
  logic              w_push;
  logic              w_pop;

  logic [34:0]       r_mem [DEPTH];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;

  // Round to nearest, ties to even, using guard/round/sticky below bit 0.
  assign w_round_up = grs_s4[2] & (grs_s4[1] | grs_s4[0] | left_shifted_mant[0]);
  assign w_m25      = {1'b0, left_shifted_mant} + {24'd0, w_round_up};
  assign w_carry    = w_m25[24];
  assign w_frac     = w_carry ? w_m25[23:1] : w_m25[22:0];
  assign w_exp      = {2'b00, exp_large_out_s4} - {2'b00, leading_zero_ctr}
                      + {9'd0, w_carry};

  always_comb begin
    w_word = {sign_out_s4, w_exp[7:0], w_frac};
    w_zero = 1'b0;
    w_uf   = 1'b0;
    w_of   = 1'b0;
    if (leading_zero_ctr >= 8'd24) begin
      w_word = 32'h0000_0000;
      w_zero = 1'b1;
    end else if (exp_large_out_s4 == 8'hFF) begin
      w_word = {sign_out_s4, 8'hFF, 23'd0};
      w_of   = 1'b1;
    end else if (w_exp <= 10'sd0) begin
      w_word = {sign_out_s4, 31'd0};
      w_uf   = 1'b1;
      w_zero = 1'b1;
    end else if (w_exp >= 10'sd255) begin
      w_word = {sign_out_s4, 8'hFF, 23'd0};
      w_of   = 1'b1;
    end
  end

  assign in_ready  = (r_count != 2'(DEPTH));
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  // Outputs read as zero whenever the queue is empty, including after reset.
  assign result    = out_valid ? r_mem[r_rd_ptr][34:3] : 32'd0;
  assign flag_zero = out_valid & r_mem[r_rd_ptr][2];
  assign flag_uf   = out_valid & r_mem[r_rd_ptr][1];
  assign flag_of   = out_valid & r_mem[r_rd_ptr][0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {w_word, w_zero, w_uf, w_of};
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_add_round_pack.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fp_add_round_pack : directed + random check of round/pack stage and queue
// Revision 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fp_add_round_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  exp_large_out_s4;
  logic [7:0]  leading_zero_ctr;
  logic [23:0] left_shifted_mant;
  logic [2:0]  grs_s4;
  logic        sign_out_s4;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        flag_zero;
  logic        flag_uf;
  logic        flag_of;

  int n_checks = 0;
  int n_errors = 0;

  // Expected queue contents: {result, zero, uf, of}
  logic [34:0] model_q[$];

  always #5 clk = ~clk;

  fp_add_round_pack #(.DEPTH(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .exp_large_out_s4 (exp_large_out_s4),
    .leading_zero_ctr (leading_zero_ctr),
    .left_shifted_mant(left_shifted_mant),
    .grs_s4           (grs_s4),
    .sign_out_s4      (sign_out_s4),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .result           (result),
    .flag_zero        (flag_zero),
    .flag_uf          (flag_uf),
    .flag_of          (flag_of)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: treat mantissa+GRS as an integer scaled by 8 and round it.
  function automatic logic [34:0] ref_pack(input logic [7:0] ex, input logic [7:0] lz,
                                           input logic [23:0] m, input logic [2:0] g,
                                           input logic s);
    longint full = longint'(m) * 8 + longint'(g);
    longint q    = full / 8;
    longint rem  = full % 8;
    longint e;
    int     c    = 0;
    if (rem > 4 || (rem == 4 && (q % 2) == 1)) q = q + 1;
    if (q == (longint'(1) << 24)) begin
      q = q / 2;
      c = 1;
    end
    e = longint'(ex) - longint'(lz) + c;
    if (lz >= 24)        return {32'h0000_0000, 3'b100};
    else if (ex == 255)  return {s, 8'hFF, 23'd0, 3'b001};
    else if (e <= 0)     return {s, 31'd0, 3'b110};
    else if (e >= 255)   return {s, 8'hFF, 23'd0, 3'b001};
    else                 return {s, 8'(e), 23'(q), 3'b000};
  endfunction

  // One clock: compare outputs with the model, drive inputs, advance the model.
  task automatic step(input logic r, input logic v, input logic [7:0] ex,
                      input logic [7:0] lz, input logic [23:0] m, input logic [2:0] g,
                      input logic s, input logic ordy);
    bit push, pop;
    check("in_ready", 64'(in_ready), 64'(model_q.size() < 2));
    check("out_valid", 64'(out_valid), 64'(model_q.size() != 0));
    if (model_q.size() != 0)
      check("head", 64'({result, flag_zero, flag_uf, flag_of}), 64'(model_q[0]));
    rst = r; in_valid = v; exp_large_out_s4 = ex; leading_zero_ctr = lz;
    left_shifted_mant = m; grs_s4 = g; sign_out_s4 = s; out_ready = ordy;
    push = !r && v && (model_q.size() < 2);
    pop  = !r && ordy && (model_q.size() != 0);
    @(posedge clk);
    if (r) model_q.delete();
    else begin
      if (pop)  void'(model_q.pop_front());
      if (push) model_q.push_back(ref_pack(ex, lz, m, g, s));
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 1'b0, 8'd0, 8'd0, 24'd0, 3'd0, 1'b0, ordy);
  endtask

  task automatic directed(input string tag, input logic [7:0] ex, input logic [7:0] lz,
                          input logic [23:0] m, input logic [2:0] g, input logic s,
                          input logic [34:0] exp_word);
    step(1'b0, 1'b1, ex, lz, m, g, s, 1'b0);
    check(tag, 64'({result, flag_zero, flag_uf, flag_of}), 64'(exp_word));
    idle(1'b1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    exp_large_out_s4 = '0; leading_zero_ctr = '0; left_shifted_mant = '0;
    grs_s4 = '0; sign_out_s4 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_result", 64'({result, flag_zero, flag_uf, flag_of}), 64'd0);

    directed("normal",   8'd130, 8'd2,  24'hC00000, 3'b000, 1'b0, {32'h40400000, 3'b000});
    directed("rne_carry",8'd127, 8'd0,  24'hFFFFFF, 3'b100, 1'b0, {32'h40000000, 3'b000});
    directed("tie_even", 8'd127, 8'd0,  24'hC00000, 3'b100, 1'b0, {32'h3FC00000, 3'b000});
    directed("zero",     8'd100, 8'd24, 24'h000000, 3'b000, 1'b1, {32'h00000000, 3'b100});
    directed("underflow",8'd3,   8'd5,  24'h800000, 3'b000, 1'b1, {32'h80000000, 3'b110});
    directed("of_round", 8'd254, 8'd0,  24'hFFFFFF, 3'b110, 1'b0, {32'h7F800000, 3'b001});
    directed("of_inexp", 8'd255, 8'd0,  24'h800000, 3'b000, 1'b1, {32'hFF800000, 3'b001});
    directed("min_norm", 8'd1,   8'd0,  24'h800000, 3'b000, 1'b0, {32'h00800000, 3'b000});
    directed("max_norm", 8'd254, 8'd0,  24'hFFFFFF, 3'b000, 1'b0, {32'h7F7FFFFF, 3'b000});

    // Backpressure: A, B fill the queue, C waits.
    step(1'b0, 1'b1, 8'd130, 8'd0, 24'h800000, 3'b000, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'd131, 8'd0, 24'h900000, 3'b000, 1'b0, 1'b0);
    check("bp_full", 64'(in_ready), 64'd0);
    step(1'b0, 1'b1, 8'd132, 8'd0, 24'hA00000, 3'b000, 1'b1, 1'b0);
    check("bp_hold_a", 64'(result), 64'h41000000);
    step(1'b0, 1'b1, 8'd132, 8'd0, 24'hA00000, 3'b000, 1'b1, 1'b1);
    check("bp_ready_after_pop", 64'(in_ready), 64'd1);
    check("bp_b", 64'(result), 64'h41900000);
    step(1'b0, 1'b1, 8'd132, 8'd0, 24'hA00000, 3'b000, 1'b1, 1'b1);
    check("bp_pushpop_valid", 64'(out_valid), 64'd1);
    check("bp_pushpop_ready", 64'(in_ready), 64'd1);
    check("bp_c", 64'(result), 64'hC2200000);
    idle(1'b1);
    check("bp_drained", 64'(out_valid), 64'd0);

    // Reset with two entries queued.
    step(1'b0, 1'b1, 8'd140, 8'd0, 24'h800000, 3'b000, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'd141, 8'd0, 24'h800000, 3'b000, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'd142, 8'd0, 24'h800000, 3'b000, 1'b0, 1'b1);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd1);
    check("mid_rst_result", 64'(result), 64'd0);
    repeat (3) idle(1'b1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      logic [7:0]  ex;
      logic [7:0]  lz;
      logic [23:0] m;
      case ($urandom_range(0, 7))
        0:       ex = 8'hFF;
        1:       ex = 8'($urandom_range(0, 30));
        2:       ex = 8'($urandom_range(240, 254));
        default: ex = 8'($urandom);
      endcase
      lz = 8'($urandom_range(0, 26));
      m  = 24'($urandom);
      if ($urandom_range(0, 3) != 0) m[23] = 1'b1;
      if ($urandom_range(0, 9) == 0) m = 24'hFFFFFF;
      step(1'($urandom_range(0, 99) == 0), 1'($urandom), ex, lz, m, 3'($urandom),
           1'($urandom), 1'($urandom_range(0, 2) != 0));
    end
    repeat (4) idle(1'b1);
    check("final_empty", 64'(out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
